// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x oversampled UART receiver (7/8 data, none/odd/even parity, 1/2 stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ticks 6/7/8.
module uart_rx_unit #(
   parameter int DIV_2400  = 1302,
   parameter int DIV_4800  = 651,
   parameter int DIV_9600  = 326,
   parameter int DIV_19200 = 163
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       data_in,
   input  logic [1:0] baud_rate,
   input  logic [1:0] parity_type,
   input  logic       data_length,
   input  logic       stop_bits,
   output logic [7:0] data_out,
   output logic       rx_active,
   output logic       rx_done,
   output logic       parity_error,
   output logic       stop_error
);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, DONE = 3'd5;
`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] SAMP = 4'd8;
   logic m6, m7;
`else
   localparam logic [3:0] SAMP = 4'd7;
`endif
   logic        s1, s2, s_prev;
   logic [2:0]  state;
   logic [10:0] div_cnt, div_max;
   logic [3:0]  tcnt;
   logic [2:0]  bcnt;
   logic [7:0]  shreg;
   logic [1:0]  baud_l, par_l;
   logic        len_l, stop_l, par_pend, stop_pend;
   logic        tick, samp, bitv, par_en, last_data, start_det, par_bad, bit_end;

   always_comb begin
      div_max   = baud_l == 2'd0 ? 11'(DIV_2400 - 1) :
                  baud_l == 2'd1 ? 11'(DIV_4800 - 1) :
                  baud_l == 2'd2 ? 11'(DIV_9600 - 1) : 11'(DIV_19200 - 1);
      tick      = state != IDLE && state != DONE && div_cnt == div_max;
      samp      = tick && tcnt == SAMP;
      bit_end   = tick && tcnt == 4'd15;
`ifdef UART_RX_MAJORITY_EN
      bitv      = (m6 & m7) | (m6 & s2) | (m7 & s2);
`else
      bitv      = s2;
`endif
      par_en    = par_l == 2'b01 || par_l == 2'b10;
      last_data = bcnt == (len_l ? 3'd7 : 3'd6);
      start_det = state == IDLE && s_prev && !s2;
      // shreg[0] stays 0 in 7-bit mode, so the reduction covers only data bits
      par_bad   = (^shreg ^ bitv) ^ (par_l == 2'b01);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         s1           <= 1'b1;
         s2           <= 1'b1;
         s_prev       <= 1'b1;
         state        <= IDLE;
         div_cnt      <= '0;
         tcnt         <= '0;
         bcnt         <= '0;
         shreg        <= '0;
         baud_l       <= '0;
         par_l        <= '0;
         len_l        <= 1'b0;
         stop_l       <= 1'b0;
         par_pend     <= 1'b0;
         stop_pend    <= 1'b0;
         data_out     <= '0;
         rx_active    <= 1'b0;
         rx_done      <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         m6           <= 1'b1;
         m7           <= 1'b1;
`endif
      end else begin
         s1      <= data_in;
         s2      <= s1;
         s_prev  <= s2;
         rx_done <= 1'b0;
         div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 11'd1;
         if (tick) tcnt <= tcnt + 4'd1;
`ifdef UART_RX_MAJORITY_EN
         if (tick && tcnt == 4'd6) m6 <= s2;
         if (tick && tcnt == 4'd7) m7 <= s2;
`endif
         case (state)
            IDLE: if (start_det) begin
               state     <= START;
               rx_active <= 1'b1;
               tcnt      <= '0;
               bcnt      <= '0;
               shreg     <= '0;
               par_pend  <= 1'b0;
               stop_pend <= 1'b0;
               baud_l    <= baud_rate;
               par_l     <= parity_type;
               len_l     <= data_length;
               stop_l    <= stop_bits;
            end
            START: if (samp && bitv) begin
               state     <= IDLE;
               rx_active <= 1'b0;
            end else if (bit_end) state <= DATA;
            DATA: begin
               if (samp) shreg <= {bitv, shreg[7:1]};
               if (bit_end) begin
                  bcnt <= last_data ? 3'd0 : bcnt + 3'd1;
                  if (last_data) state <= par_en ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (samp) par_pend <= par_bad;
               if (bit_end) state <= STOP;
            end
            // Leave at the last stop mid-sample so a back-to-back start edge is caught
            STOP: if (samp) begin
               if (bcnt == {2'b00, stop_l}) begin
                  state        <= DONE;
                  rx_done      <= 1'b1;
                  rx_active    <= 1'b0;
                  data_out     <= len_l ? shreg : {1'b0, shreg[7:1]};
                  parity_error <= par_pend;
                  stop_error   <= stop_pend | ~bitv;
               end else begin
                  stop_pend <= stop_pend | ~bitv;
                  bcnt      <= bcnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: directed frames against uart_rx_unit with shortened baud dividers.
module tb_uart_rx_unit;
   localparam int D0 = 11, D1 = 9, D2 = 7, D3 = 5;
   logic       clock = 1'b0, rst = 1'b1, data_in = 1'b1;
   logic [1:0] baud_rate = 2'd3, parity_type = 2'd0;
   logic       data_length = 1'b1, stop_bits = 1'b0;
   logic [7:0] data_out;
   logic       rx_active, rx_done, parity_error, stop_error;
   int         errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, n0;
   logic [7:0] rxq[$];
   logic [7:0] r0, r1;

   uart_rx_unit #(.DIV_2400(D0), .DIV_4800(D1), .DIV_9600(D2), .DIV_19200(D3)) dut (
      .clock(clock), .rst(rst), .data_in(data_in), .baud_rate(baud_rate),
      .parity_type(parity_type), .data_length(data_length), .stop_bits(stop_bits),
      .data_out(data_out), .rx_active(rx_active), .rx_done(rx_done),
      .parity_error(parity_error), .stop_error(stop_error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      rxq.push_back(data_out);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // bits[0] is the start bit, sent first; line returns high afterwards
   task automatic send(input logic [31:0] bits, input int n, input int d);
      @(negedge clock);
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         data_in = bits[i];
         repeat (16 * d) @(negedge clock);
      end
      data_in = 1'b1;
   endtask

   task automatic idle(input int d);
      repeat (32 * d) @(negedge clock);
   endtask

   initial begin
      repeat (5) @(negedge clock);
      check("rst data_out", data_out, 8'h00);
      check("rst rx_active", rx_active, 1'b0);
      check("rst rx_done", rx_done, 1'b0);
      check("rst parity_error", parity_error, 1'b0);
      check("rst stop_error", stop_error, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clock);

      n0 = done_cnt;
      send({1'b1, 8'hA5, 1'b0}, 10, D3);
      idle(D3);
      check("8N1 done count", done_cnt - n0, 1);
      check("8N1 latency", done_cyc - start_cyc, 3 + 152 * D3);
      check("8N1 data", data_out, 8'hA5);
      check("8N1 parity_error", parity_error, 1'b0);
      check("8N1 stop_error", stop_error, 1'b0);
      check("8N1 rx_active", rx_active, 1'b0);

      baud_rate = 2'd2; parity_type = 2'b10; data_length = 1'b0; stop_bits = 1'b1;
      n0 = done_cnt;
      send({2'b11, 1'b0, 7'h35, 1'b0}, 11, D2);
      idle(D2);
      check("7E2 good done", done_cnt - n0, 1);
      check("7E2 good data", data_out, 8'h35);
      check("7E2 good parity_error", parity_error, 1'b0);
      send({2'b11, 1'b1, 7'h35, 1'b0}, 11, D2);
      idle(D2);
      check("7E2 bad done", done_cnt - n0, 2);
      check("7E2 bad data", data_out, 8'h35);
      check("7E2 bad parity_error", parity_error, 1'b1);

      baud_rate = 2'd3; parity_type = 2'b01; data_length = 1'b1; stop_bits = 1'b0;
      n0 = done_cnt;
      send({1'b0, 1'b1, 8'h00, 1'b0}, 11, D3);
      idle(D3);
      check("8O1 done", done_cnt - n0, 1);
      check("8O1 data", data_out, 8'h00);
      check("8O1 parity_error", parity_error, 1'b0);
      check("8O1 stop_error", stop_error, 1'b1);

      n0 = done_cnt;
      @(negedge clock);
      data_in = 1'b0;
      repeat (2 * D3) @(negedge clock);
      check("glitch rx_active high", rx_active, 1'b1);
      repeat (2 * D3) @(negedge clock);
      data_in = 1'b1;
      idle(D3);
      check("glitch rx_active low", rx_active, 1'b0);
      check("glitch no done", done_cnt - n0, 0);
      check("glitch data kept", data_out, 8'h00);
      check("glitch stop_error kept", stop_error, 1'b1);

      parity_type = 2'b00;
      rxq.delete();
      send({1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}, 20, D3);
      idle(D3);
      r0 = rxq.size() > 0 ? rxq[0] : 8'hxx;
      r1 = rxq.size() > 1 ? rxq[1] : 8'hxx;
      check("b2b count", rxq.size(), 2);
      check("b2b first", r0, 8'h3C);
      check("b2b second", r1, 8'hC3);

      n0 = done_cnt;
      @(negedge clock);
      data_in = 1'b0;
      repeat (32 * D3) @(negedge clock);
      data_in = 1'b1;
      repeat (8 * D3) @(negedge clock);
      check("mid rx_active", rx_active, 1'b1);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      check("abort rx_active", rx_active, 1'b0);
      check("abort data_out", data_out, 8'h00);
      idle(D3);
      check("abort no done", done_cnt - n0, 0);
      send({1'b1, 8'h5A, 1'b0}, 10, D3);
      idle(D3);
      check("after abort done", done_cnt - n0, 1);
      check("after abort data", data_out, 8'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
UART receive path, the downstream peer of the Tx unit. It deserialises the line driven by the Tx unit's data_out, using the same frame options: 7/8 data bits, none/odd/even parity, 1/2 stop bits. It generates its own 16x oversampling tick from baud_rate, checks parity and stop bits, and presents each received byte with a one-cycle done pulse.

Parameters:
DIV_2400, 1302, clock cycles per 16x tick at 2400 baud (50 MHz clock)
DIV_4800, 651, clock cycles per 16x tick at 4800 baud
DIV_9600, 326, clock cycles per 16x tick at 9600 baud
DIV_19200, 163, clock cycles per 16x tick at 19200 baud

Ports:
clock  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  1  serial line; idles high; asynchronous to clock
baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200
parity_type  input  2  00=none, 01=odd, 10=even, 11=none
data_length  input  1  0=7 data bits, 1=8 data bits
stop_bits  input  1  0=one stop bit, 1=two stop bits
data_out  output  8  last received data, LSB-first reassembled; bit7=0 in 7-bit mode
rx_active  output  1  high from start-bit detection until the frame ends or is aborted
rx_done  output  1  one-cycle pulse when data_out/errors update
parity_error  output  1  parity mismatch on last frame; 0 when parity is disabled
stop_error  output  1  any sampled stop bit was 0 on last frame

Behaviour:
- Reset: all outputs 0; FSM in IDLE; divider and counters 0; synchroniser flops preset to 1.
- data_in passes through a 2-flop synchroniser. All references below use the synchronised value.
- Tick divider:
  - Counts 0..DIV-1 and emits tick on DIV-1.
  - DIV is selected by the baud_rate latched at start detect.
  - The divider is cleared on start detect so ticks are frame-aligned.
- Frame config (baud_rate, parity_type, data_length, stop_bits) is latched on start detect. Changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE. A 4-bit tick counter (0..15) and a bit counter run alongside.
  - IDLE: a synchronised 1->0 transition goes to START, sets rx_active=1 and clears the tick counter.
  - START: sampled at tick counter 7.
    - Sample 1 (false start): return to IDLE, rx_active=0, no rx_done, outputs unchanged.
    - Sample 0: at tick counter 15, go to DATA.
  - DATA:
    - Sample at tick 7 of each 16-tick bit and shift in LSB-first.
    - After 7 or 8 bits (per data_length), go to PARITY if parity is enabled, else STOP.
  - PARITY: sample at tick 7.
    - Odd: error if data XOR sampled parity bit == 0.
    - Even: error if that XOR == 1.
  - STOP:
    - Sample at tick 7 of each stop bit; any 0 sets the pending stop error.
    - After the mid-sample of the last stop bit, go to DONE without waiting for the bit end. This allows resync to a back-to-back start bit.
  - DONE (one cycle): update data_out, parity_error and stop_error; pulse rx_done=1; set rx_active=0; return to IDLE.
- Error flags and data_out hold until the next DONE. A stop error still delivers data.
- Latency: rx_done rises 1 clock after the last stop-bit mid-sample.
- A line held low (break) produces a frame with stop_error=1. IDLE then waits for the line to go high before arming a new start detect.
- Reset asserted mid-frame: the frame is aborted immediately, with no rx_done and all outputs cleared.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value is the 2-of-3 majority of the samples at tick counts 6, 7 and 8; the decision is taken at tick 8. This applies to start-bit validation too.
- Undefined: single sample at tick count 7. Cycle timing of rx_done is otherwise identical in both builds.

Test Plan:
- 8N1, 19200 baud, send 0xA5 -> rx_done pulses once, ~16*163*10 clocks after the start edge; data_out=0xA5; both errors 0.
- 7-bit, even parity, 2 stop, 9600 baud, send 0x35 with parity bit 0 -> data_out=0x35, parity_error=0. Repeat with parity bit 1 -> parity_error=1, data still 0x35.
- 8O1, send 0x00 with stop bit forced 0 -> stop_error=1, parity_error=0, data_out=0x00.
- Low glitch of 4*DIV clocks on an idle line -> no rx_done, rx_active returns to 0, data_out unchanged.
- Two back-to-back 8N1 frames 0x3C then 0xC3 with no idle gap -> two rx_done pulses with the correct data in order.
- rst pulsed during the DATA state of a frame -> outputs 0, no rx_done; the next clean frame 0x5A is received correctly.
